// File: rtl/process_run_controller_pkg.sv
// rtl/process_run_controller_pkg.sv - shared state encoding and width helper for the run sequencer
package process_run_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DELAY   = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/process_run_controller_sat_up_counter.sv
// rtl/process_run_controller_sat_up_counter.sv - clearable up counter that sticks at MAX
module sat_up_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Clear has priority; counting stops at MAX so the value never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/process_run_controller.sv
// rtl/process_run_controller.sv - start delay, watchdog and core-done collection for one processor run
module process_run_controller
    import process_run_controller_pkg::*;
#(
    parameter int  NUM_CORES   = 3,
    parameter int  START_DELAY = 10,
    parameter int  MAX_CYCLES  = 8000,
    parameter bit  AUTO_START  = 1'b1,
    localparam int CNT_W       = cnt_width(MAX_CYCLES)
) (
    input  logic                 fast_clock,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 clear,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 start_process,
    output logic                 run_active,
    output logic                 run_done,
    output logic                 run_timeout,
    output logic [NUM_CORES-1:0] done_mask,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam int               DLY_W    = cnt_width(START_DELAY);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY > 0 ? START_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state;
    logic             auto_pending;
    logic [DLY_W-1:0] delay_cnt;
    logic             abort;
    logic             all_done;

    // A clear outside IDLE wins over every other transition.
    assign abort    = clear && (state != S_IDLE);
    // Include this edge's done inputs so a late pulse still completes the run.
    assign all_done = &(done_mask | core_done);

    // Delay counter only advances while in DELAY and restarts from zero on each entry.
    sat_up_counter #(.W(DLY_W), .MAX(START_DELAY)) u_delay_cnt (
        .clk   (fast_clock),
        .rst_n (rst_n),
        .clr   ((state != S_DELAY) || abort),
        .en    (state == S_DELAY),
        .count (delay_cnt)
    );

    // Cycle counter is held after exit; only clear (or reset) returns it to zero.
    sat_up_counter #(.W(CNT_W), .MAX(MAX_CYCLES)) u_cycle_cnt (
        .clk   (fast_clock),
        .rst_n (rst_n),
        .clr   (clear),
        .en    (state == S_RUN),
        .count (cycle_count)
    );

    // Run sequencer; outputs are registered alongside the state they describe.
    always_ff @(posedge fast_clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            auto_pending  <= AUTO_START;
            start_process <= 1'b0;
            run_active    <= 1'b0;
            run_done      <= 1'b0;
            run_timeout   <= 1'b0;
            done_mask     <= '0;
        end else if (abort) begin
            state         <= S_IDLE;
            start_process <= 1'b0;
            run_active    <= 1'b0;
            run_done      <= 1'b0;
            run_timeout   <= 1'b0;
            done_mask     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!clear && (arm || auto_pending)) begin
                        auto_pending <= 1'b0;
                        run_active   <= 1'b1;
                        if (START_DELAY > 0) begin
                            state <= S_DELAY;
                        end else begin
                            state         <= S_RUN;
                            start_process <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (delay_cnt == DLY_LAST) begin
                        state         <= S_RUN;
                        start_process <= 1'b1;
                    end
                end
                S_RUN: begin
                    done_mask <= done_mask | core_done;
                    if (all_done) begin
                        state         <= S_DONE;
                        run_done      <= 1'b1;
                        start_process <= 1'b0;
                        run_active    <= 1'b0;
                    end else if (cycle_count == CNT_LAST) begin
                        state         <= S_TIMEOUT;
                        run_timeout   <= 1'b1;
                        start_process <= 1'b0;
                        run_active    <= 1'b0;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    state <= state;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_process_run_controller.sv
// tb/tb_process_run_controller.sv - table, hand-sequence and randomized model checks of the run sequencer
module tb_process_run_controller;

    localparam int MAX1 = 8000;
    localparam int MAX2 = 20;

    logic        clk = 1'b0;
    logic        rst_n, arm, clear;
    logic [2:0]  core_done;
    logic        start_process, run_active, run_done, run_timeout;
    logic [2:0]  done_mask;
    logic [12:0] cycle_count;

    logic        rst2_n, arm2, clear2;
    logic [1:0]  core2;
    logic        start2, active2, done2, tout2;
    logic [1:0]  mask2;
    logic [4:0]  count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    process_run_controller dut (
        .fast_clock    (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .clear         (clear),
        .core_done     (core_done),
        .start_process (start_process),
        .run_active    (run_active),
        .run_done      (run_done),
        .run_timeout   (run_timeout),
        .done_mask     (done_mask),
        .cycle_count   (cycle_count)
    );

    process_run_controller #(
        .NUM_CORES   (2),
        .START_DELAY (0),
        .MAX_CYCLES  (MAX2),
        .AUTO_START  (1'b0)
    ) dut2 (
        .fast_clock    (clk),
        .rst_n         (rst2_n),
        .arm           (arm2),
        .clear         (clear2),
        .core_done     (core2),
        .start_process (start2),
        .run_active    (active2),
        .run_done      (done2),
        .run_timeout   (tout2),
        .done_mask     (mask2),
        .cycle_count   (count2)
    );

    typedef struct {
        string      name;
        int         p0, p1, p2;
        bit         exp_done, exp_to;
        logic [2:0] exp_mask;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_start1(input string name);
        for (int i = 0; i < 40 && !start_process; i++) cycle();
        check(name, start_process, 1);
    endtask

    // Drive single-cycle pulses at the given RUN indices until the run ends.
    task automatic run_vec1(input int p0, input int p1, input int p2);
        int idx = 0;
        while (!(run_done || run_timeout) && idx < MAX1 + 5) begin
            core_done = {idx == p2, idx == p1, idx == p0};
            cycle();
            idx++;
        end
        core_done = '0;
    endtask

    task automatic check_result1(input vec_t v);
        check({v.name, " done"},    run_done,      v.exp_done);
        check({v.name, " timeout"}, run_timeout,   v.exp_to);
        check({v.name, " mask"},    done_mask,     v.exp_mask);
        check({v.name, " count"},   cycle_count,   v.exp_cnt);
        check({v.name, " start"},   start_process, 0);
        check({v.name, " active"},  run_active,    0);
    endtask

    // Reference outcome of one run: first index where every core has been seen, else timeout.
    task automatic model_run(input logic [1:0] pat[MAX2], output bit d, output bit t,
                             output logic [1:0] m, output int c);
        m = '0; d = 0; t = 1; c = MAX2;
        for (int i = 0; i < MAX2; i++) begin
            m = m | pat[i];
            if (m == 2'b11) begin
                d = 1; t = 0; c = i + 1;
                break;
            end
        end
    endtask

    initial begin
        vecs[0] = '{"pulses", 5, 40, 20, 1'b1, 1'b0, 3'b111, 41};
        vecs[1] = '{"timeout", 3, -1, 100, 1'b0, 1'b1, 3'b101, 8000};
        vecs[2] = '{"last_edge", 0, 7999, 50, 1'b1, 1'b0, 3'b111, 8000};
        vecs[3] = '{"all_first", 0, 0, 0, 1'b1, 1'b0, 3'b111, 1};

        rst_n = 0; arm = 0; clear = 0; core_done = '0;
        rst2_n = 0; arm2 = 0; clear2 = 0; core2 = '0;
        repeat (3) cycle();
        check("reset active", run_active, 0);
        check("reset start", start_process, 0);
        check("reset flags", {run_done, run_timeout}, 0);
        check("reset mask_count", {done_mask, cycle_count}, 0);
        check("reset2 all", {start2, active2, done2, tout2, mask2, count2}, 0);

        // Auto start: active after edge 1, start_process after edge 11.
        rst_n = 1;
        cycle();
        check("auto active e1", run_active, 1);
        check("auto start e1", start_process, 0);
        repeat (9) cycle();
        check("auto start e10", start_process, 0);
        cycle();
        check("auto start e11", start_process, 1);
        check("auto count0", cycle_count, 0);

        for (int v = 0; v < 4; v++) begin
            if (v > 0) begin
                clear = 1; cycle(); clear = 0;
                check({vecs[v].name, " cleared"}, {run_done, run_timeout, done_mask, cycle_count}, 0);
                arm = 1; cycle(); arm = 0;
                wait_start1({vecs[v].name, " started"});
            end
            run_vec1(vecs[v].p0, vecs[v].p1, vecs[v].p2);
            check_result1(vecs[v]);
        end

        // Clear mid-RUN, then re-arm from zero; arm with clear in IDLE stays IDLE.
        clear = 1; cycle(); clear = 0;
        arm = 1; cycle(); arm = 0;
        wait_start1("abort started");
        repeat (100) cycle();
        check("abort pre count", cycle_count, 100);
        clear = 1; cycle(); clear = 0;
        check("abort start", start_process, 0);
        check("abort active", run_active, 0);
        check("abort count", cycle_count, 0);
        arm = 1; cycle(); arm = 0;
        wait_start1("rearm started");
        check("rearm count0", cycle_count, 0);
        repeat (5) cycle();
        check("rearm count5", cycle_count, 5);
        clear = 1; cycle(); clear = 0;
        arm = 1; clear = 1; cycle(); arm = 0; clear = 0;
        check("arm+clear idle", run_active, 0);
        repeat (5) cycle();
        check("arm+clear still idle", run_active, 0);

        // Reset asserted between edges while in DELAY.
        arm = 1; cycle(); arm = 0;
        repeat (3) cycle();
        check("delay active", run_active, 1);
        #1 rst_n = 0;
        #1 check("async reset", {start_process, run_active, run_done, run_timeout, done_mask, cycle_count}, 0);
        @(negedge clk);
        rst_n = 1;
        cycle();
        check("post reset auto active", run_active, 1);

        // Second instance: no auto start, zero delay, short watchdog.
        rst2_n = 1;
        repeat (30) cycle();
        check("noauto idle", active2, 0);
        for (int r = 0; r < 30; r++) begin
            logic [1:0] pat[MAX2];
            bit ed, et;
            logic [1:0] em;
            int ec, idx;
            for (int i = 0; i < MAX2; i++)
                pat[i] = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
            model_run(pat, ed, et, em, ec);
            core2 = 2'($urandom);
            arm2 = 1; cycle(); arm2 = 0;
            check("r start0", start2, 1);
            idx = 0;
            while (!(done2 || tout2) && idx < MAX2 + 3) begin
                core2 = (idx < MAX2) ? pat[idx] : 2'b00;
                cycle();
                idx++;
            end
            core2 = 2'b11;
            repeat (2) cycle();
            core2 = '0;
            check("r done", done2, ed);
            check("r timeout", tout2, et);
            check("r mask", mask2, em);
            check("r count", count2, ec);
            check("r start", start2, 0);
            clear2 = 1; cycle(); clear2 = 0;
            check("r cleared", {done2, tout2, mask2, count2}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
